// File: rtl/div_pkg.sv
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types for the sequential signed integer divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_int.sv
// ============================================================================
//  Module   : div_int
//  Purpose  : Signed restoring divider, one quotient bit per clock, DSZ+2
//             edge latency, truncating toward zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_int
  import div_pkg::*;
#(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic           busy,
  output logic           dbz,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r
);

  localparam int             CNT_W = $clog2(DSZ + 1);
  localparam logic [DSZ-1:0] ONE   = DSZ'(1);

  generate
    if ((DSZ < 4) || ((DSZ % 2) != 0)) begin : g_bad_dsz
      $error("div_int: DSZ must be even and at least 4");
    end
  endgenerate

  div_state_e       state_q, state_d;
  logic [DSZ:0]     rem_q, rem_d;
  logic [DSZ-1:0]   quo_q, quo_d;
  logic [DSZ-1:0]   dvs_q, dvs_d;
  logic [DSZ-1:0]   q_q, q_d;
  logic [DSZ-1:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_x_q, neg_x_d;
  logic             neg_y_q, neg_y_d;
  logic             dbz_q, dbz_d;

  logic [DSZ-1:0]   w_abs_x;
  logic [DSZ-1:0]   w_abs_y;
  logic [DSZ:0]     w_shift;
  logic             w_fit;
  logic             w_y_zero;
  logic             w_rem_unused;

  // Unsigned negation, so the most-negative value maps to 2^(DSZ-1).
  assign w_abs_x  = x[DSZ-1] ? (~x + ONE) : x;
  assign w_abs_y  = y[DSZ-1] ? (~y + ONE) : y;
  assign w_y_zero = (y == '0);

  // Dividend bits are shifted out of quo_q as quotient bits shift in.
  assign w_shift      = {rem_q[DSZ-1:0], quo_q[DSZ-1]};
  assign w_fit        = (w_shift >= {1'b0, dvs_q});
  assign w_rem_unused = rem_q[DSZ];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = w_y_zero ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
  end

  assign dbz = dbz_q;
  assign q   = q_q;
  assign r   = r_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    neg_x_d = neg_x_q;
    neg_y_d = neg_y_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (w_y_zero) begin
          dbz_d = 1'b1;
          q_d   = '0;
          r_d   = x;
        end else begin
          rem_d   = '0;
          quo_d   = w_abs_x;
          dvs_d   = w_abs_y;
          neg_x_d = x[DSZ-1];
          neg_y_d = y[DSZ-1];
          cnt_d   = CNT_W'(DSZ);
        end
      end
      CALC: begin
        rem_d = w_fit ? (w_shift - {1'b0, dvs_q}) : w_shift;
        quo_d = {quo_q[DSZ-2:0], w_fit};
        cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        q_d = (neg_x_q ^ neg_y_q) ? (~quo_q + ONE) : quo_q;
        r_d = neg_x_q ? (~rem_q[DSZ-1:0] + ONE) : rem_q[DSZ-1:0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      neg_x_q <= 1'b0;
      neg_y_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      neg_x_q <= neg_x_d;
      neg_y_q <= neg_y_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule : div_int

`default_nettype wire

// File: tb/tb_div_int.sv
// ============================================================================
//  Module   : tb_div_int
//  Purpose  : Directed self-checking bench for div_int with DSZ = 32.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_int;

  localparam int DSZ = 32;

  logic           clk;
  logic           rst;
  logic [DSZ-1:0] x;
  logic [DSZ-1:0] y;
  logic           busy;
  logic           dbz;
  logic [DSZ-1:0] q;
  logic [DSZ-1:0] r;

  int cmp_cnt = 0;
  int err_cnt = 0;

  div_int #(.DSZ(DSZ)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .busy (busy),
    .dbz  (dbz),
    .q    (q),
    .r    (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset low for one cycle with new operands, release on a falling edge.
  task automatic start_run(input logic [DSZ-1:0] a, input logic [DSZ-1:0] b);
    @(negedge clk);
    rst = 1'b0;
    x   = a;
    y   = b;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Advance n rising edges, sampling 1 time unit after each; count busy samples.
  task automatic wait_edges(input int n, output int nbusy);
    nbusy = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) nbusy++;
    end
  endtask

  task automatic test_reset;
    #2;
    cmp_cnt++;
    if ({busy, dbz} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_flags: busy/dbz got %b required 00", {busy, dbz});
    end
    cmp_cnt++;
    if ({q, r} !== '0) begin
      err_cnt++;
      $display("FAIL reset_qr: q=%h r=%h required 0/0", q, r);
    end
  endtask

  task automatic test_basic;
    int nb;
    bit stable;
    start_run(32'h20, 32'h10);
    wait_edges(DSZ + 1, nb);
    cmp_cnt++;
    if (nb !== DSZ + 1) begin
      err_cnt++;
      $display("FAIL basic_busy_len: got %0d required %0d", nb, DSZ + 1);
    end
    cmp_cnt++;
    if ({q, r} !== '0) begin
      err_cnt++;
      $display("FAIL basic_pre_fix: q=%h r=%h required 0/0", q, r);
    end
    wait_edges(1, nb);
    cmp_cnt++;
    if (q !== 32'h2 || r !== 32'h0 || dbz !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_result: q=%h r=%h dbz=%b busy=%b required 2/0/0/0", q, r, dbz, busy);
    end
    stable = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (q !== 32'h2 || r !== 32'h0 || dbz !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    cmp_cnt++;
    if (stable !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_hold: last q=%h r=%h busy=%b required stable 2/0/0", q, r, busy);
    end
  endtask

  task automatic test_vector(input string name, input logic [DSZ-1:0] a,
                             input logic [DSZ-1:0] b, input logic [DSZ-1:0] eq,
                             input logic [DSZ-1:0] er);
    int nb;
    start_run(a, b);
    wait_edges(DSZ + 2, nb);
    cmp_cnt++;
    if (q !== eq || r !== er || dbz !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s: q=%h r=%h dbz=%b busy=%b required q=%h r=%h dbz=0 busy=0",
               name, q, r, dbz, busy, eq, er);
    end
  endtask

  task automatic test_signed;
    test_vector("neg7_div_2",   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD, 32'hFFFF_FFFF);
    test_vector("7_div_neg2",   32'h7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h1);
    test_vector("neg100_neg7",  32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE);
    test_vector("5_div_7",      32'd5,         32'd7,          32'd0,         32'd5);
  endtask

  task automatic test_boundary;
    test_vector("minneg_div_m1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    test_vector("maxpos_div_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         32'h7FFF_FFFF);
    test_vector("min_div_min",    32'h8000_0000, 32'h8000_0000, 32'h1,         32'h0);
  endtask

  task automatic test_dbz;
    int nb;
    start_run(32'h1234_5678, 32'h0);
    wait_edges(1, nb);
    cmp_cnt++;
    if (dbz !== 1'b1 || q !== 32'h0 || r !== 32'h1234_5678 || nb !== 0) begin
      err_cnt++;
      $display("FAIL dbz_first_edge: dbz=%b q=%h r=%h busy_cnt=%0d required 1/0/12345678/0",
               dbz, q, r, nb);
    end
    wait_edges(DSZ + 4, nb);
    cmp_cnt++;
    if (nb !== 0 || dbz !== 1'b1 || r !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL dbz_hold: busy_cnt=%0d dbz=%b r=%h required 0/1/12345678", nb, dbz, r);
    end
  endtask

  task automatic test_abort;
    int nb;
    start_run(32'd100, 32'd7);
    wait_edges(10, nb);
    #2;
    rst = 1'b0;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || dbz !== 1'b0 || q !== 32'h0 || r !== 32'h0) begin
      err_cnt++;
      $display("FAIL abort_async_clear: busy=%b dbz=%b q=%h r=%h required 0/0/0/0",
               busy, dbz, q, r);
    end
    @(negedge clk);
    x   = 32'd100;
    y   = 32'd7;
    rst = 1'b1;
    wait_edges(DSZ + 2, nb);
    cmp_cnt++;
    if (q !== 32'd14 || r !== 32'd2 || busy !== 1'b0 || nb !== DSZ + 1) begin
      err_cnt++;
      $display("FAIL abort_rerun: q=%h r=%h busy=%b busy_cnt=%0d required e/2/0/%0d",
               q, r, busy, nb, DSZ + 1);
    end
  endtask

  task automatic test_sample_once;
    int nb;
    start_run(32'h20, 32'h10);
    @(posedge clk);
    #1;
    x = 32'hFFFF;
    y = 32'h3;
    wait_edges(DSZ + 1, nb);
    cmp_cnt++;
    if (q !== 32'h2 || r !== 32'h0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL sample_once: q=%h r=%h busy=%b required 2/0/0", q, r, busy);
    end
  endtask

  initial begin
    rst = 1'b0;
    x   = '0;
    y   = '0;
    test_reset();
    test_basic();
    test_signed();
    test_boundary();
    test_dbz();
    test_abort();
    test_sample_once();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_div_int

`default_nettype wire
